// File: rtl/booth_seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// booth_seq_mult_ctrl
//
// Iterative radix-4 Booth multiplier. A single Booth encoder slice steps over
// the multiplier two bits per clock, adding a shifted partial product of the
// multiplicand into a 2*WIDTH+2 bit accumulator. One operation in flight,
// valid/ready handshake on both sides.
//
// Parameters
//   WIDTH      operand width (signed, two's complement); even and >= 4
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   controller idle and able to accept operands
//   mcand      multiplicand X (signed)
//   mplier     multiplier Y (signed)
//   out_valid  product valid, held until out_ready
//   out_ready  consumer accepts the product
//   product    exact signed X*Y (2*WIDTH bits)
//   busy       operation running or result waiting
//
// Build option
//   BOOTH_EARLY_TERM_EN  when defined, the controller finishes as soon as all
//                        remaining multiplier bits (plus the overlap bit) are
//                        identical, since every further partial product is 0.
//                        Without it, every operation takes WIDTH/2 iterations.
// -----------------------------------------------------------------------------
module booth_seq_mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int ITERS = WIDTH / 2;
  localparam int CNT_W = $clog2(ITERS);
  localparam int PPW   = WIDTH + 2;      // room for -2X of the most negative X
  localparam int ACCW  = 2 * WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {PP_ZERO, PP_X, PP_2X}  pp_op_e;

  typedef struct packed {
    pp_op_e op;
    logic   neg;
  } booth_t;

  // Radix-4 Booth recoding of {Y[2i+1], Y[2i], Y[2i-1]}.
  function automatic booth_t booth_encode(input logic [2:0] bits);
    booth_t b;
    b.op  = PP_ZERO;
    b.neg = 1'b0;
    unique case (bits)
      3'b001, 3'b010: b.op = PP_X;
      3'b011:         b.op = PP_2X;
      3'b100:         begin b.op = PP_2X; b.neg = 1'b1; end
      3'b101, 3'b110: begin b.op = PP_X;  b.neg = 1'b1; end
      default:        b.op = PP_ZERO;   // 000 / 111
    endcase
    return b;
  endfunction

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH:0]       y_q;             // {Y, 1'b0}, shifted right 2 per step
  logic [ACCW-1:0]      acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;

  booth_t               booth;
  logic [PPW-1:0]       x_ext;
  logic [PPW-1:0]       pp_mag;
  logic [PPW-1:0]       pp;
  logic [ACCW-1:0]      pp_shift;
  logic [ACCW-1:0]      acc_sum;
  logic [WIDTH:0]       y_shift;
  logic                 last_iter;
  logic                 early;
  logic                 finish;

  // ---------------------------------------------------------------------------
  // Datapath: one partial product per RUN cycle
  // ---------------------------------------------------------------------------
  assign booth = booth_encode(y_q[2:0]);
  assign x_ext = {{2{x_q[WIDTH-1]}}, x_q};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pp_mag = '0;
    unique case (booth.op)
      PP_X:    pp_mag = x_ext;
      PP_2X:   pp_mag = x_ext << 1;
      default: pp_mag = '0;
    endcase
  end

  assign pp       = booth.neg ? -pp_mag : pp_mag;
  assign pp_shift = {{WIDTH{pp[PPW-1]}}, pp} << {cnt_q, 1'b0};
  assign acc_sum  = acc_q + pp_shift;

  // Sign-filling shift keeps the "remaining bits all equal" test trivial.
  assign y_shift   = {{2{y_q[WIDTH]}}, y_q[WIDTH:2]};
  assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

`ifdef BOOTH_EARLY_TERM_EN
  // Remaining bits plus overlap all 0 or all 1 -> every later digit is zero.
  assign early = (y_shift == '0) || (y_shift == '1);
`else
  assign early = 1'b0;
`endif

  assign finish = last_iter || early;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // sample their inputs from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (finish)    state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_RUN) || (state_q == S_DONE);
  end

  assign product = product_q;

  // ---------------------------------------------------------------------------
  // Operand, accumulator and result registers
  // ---------------------------------------------------------------------------
  // NOTE: datapath registers are reset too, so product reads 0 after reset and
  // an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q   <= mcand;
            y_q   <= {mplier, 1'b0};
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        S_RUN: begin
          acc_q <= acc_sum;
          y_q   <= y_shift;
          cnt_q <= cnt_q + 1'b1;
          // Result register only moves on the final step: no partial sums seen.
          if (finish) product_q <= acc_sum[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_mult_ctrl
//
// Directed and random checks for booth_seq_mult_ctrl (WIDTH=32): reset state,
// products and latency, signed corner operands, backpressure hold, reset abort,
// and early-termination latency when BOOTH_EARLY_TERM_EN is defined.
// -----------------------------------------------------------------------------
module tb_booth_seq_mult_ctrl;

  localparam int W     = 32;
  localparam int ITERS = W / 2;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  product;
  logic            busy;

  int checks = 0;
  int errors = 0;

  booth_seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplier    (mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Expected cycle count from accept to out_valid.
  function automatic int exp_lat(input logic [W-1:0] y);
    logic signed [W:0] s;
    logic signed [W:0] t;
    if (!EARLY) return ITERS;
    s = {y, 1'b0};
    for (int i = 0; i < ITERS; i++) begin
      t = s >>> (2 * (i + 1));
      if (t == '0 || t == '1) return i + 1;
    end
    return ITERS;
  endfunction

  // Present one operand pair and hold it through the accepting edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int n = 0; n < 50 && !in_ready; n++) begin
      @(posedge clk); #1;
    end
    mcand    = x;
    mplier   = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept until out_valid; timeout reported via flag.
  task automatic wait_valid(output int lat, output bit timeout);
    lat     = 0;
    timeout = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat     = n;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mcand = '0; mplier = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL reset_product: got %h expected 0", product); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; bit to;
    start_op(32'd7, 32'hFFFF_FFFD);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_run_flags: in_ready=%b busy=%b expected 0/1", in_ready, busy); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL basic_no_partial: got %h expected 0", product); end
    wait_valid(lat, to);
    checks++; if (to || lat != exp_lat(32'hFFFF_FFFD)) begin errors++; $display("FAIL basic_latency: got %0d (timeout=%0b) expected %0d", lat, to, exp_lat(32'hFFFF_FFFD)); end
    checks++; if (product !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL basic_product: got %h expected ffffffffffffffeb", product); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_done_flags: busy=%b in_ready=%b expected 1/0", busy, in_ready); end
    release_result();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_return_idle: out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
  endtask

  task automatic test_edges();
    logic [W-1:0]   xs [5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0]   ys [5] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [2*W-1:0] ps [5] = '{64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000,
                               64'h3FFF_FFFF_0000_0001, 64'h0000_0000_0000_0001,
                               64'hC000_0000_8000_0000};
    int lat; bit to;
    for (int i = 0; i < 5; i++) begin
      start_op(xs[i], ys[i]);
      wait_valid(lat, to);
      checks++; if (to || product !== ps[i]) begin errors++; $display("FAIL edge_%0d_product: got %h (timeout=%0b) expected %h", i, product, to, ps[i]); end
      checks++; if (lat != exp_lat(ys[i])) begin errors++; $display("FAIL edge_%0d_latency: got %0d expected %0d", i, lat, exp_lat(ys[i])); end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to; bit held_ok; bit extra;
    start_op(32'd5, 32'd6);
    wait_valid(lat, to);
    checks++; if (to || product !== 64'd30) begin errors++; $display("FAIL bp_product: got %h (timeout=%0b) expected 1e", product, to); end
    held_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin mcand = 32'd11; mplier = 32'd13; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || product !== 64'd30 || in_ready !== 1'b0) held_ok = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (!held_ok) begin errors++; $display("FAIL bp_hold: out_valid=%b product=%h in_ready=%b expected 1/1e/0 throughout", out_valid, product, in_ready); end
    release_result();
    extra = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) extra = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (extra) begin errors++; $display("FAIL bp_ignored_input: out_valid=%b in_ready=%b expected no second result", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit to; bit seen;
    start_op(32'd100, 32'h5A5A_5A5A);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_pre_state: busy=%b out_valid=%b expected 1/0", busy, out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || product !== 64'd0) begin
      errors++; $display("FAIL abort_idle: in_ready=%b busy=%b out_valid=%b product=%h expected 1/0/0/0", in_ready, busy, out_valid, product);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_result: out_valid asserted after abort, expected never"); end
    start_op(32'd3, 32'd5);
    wait_valid(lat, to);
    checks++; if (to || product !== 64'd15) begin errors++; $display("FAIL abort_next_op: got %h (timeout=%0b) expected f", product, to); end
    release_result();
  endtask

  task automatic test_early_term();
    logic [W-1:0]   xs [4] = '{32'd12345, 32'd3, 32'hFFFF_FFFB, 32'd9};
    logic [W-1:0]   ys [4] = '{32'd1, 32'h0000_FFFF, 32'd0, 32'hFFFF_FFFF};
    logic [2*W-1:0] ps [4] = '{64'd12345, 64'd196605, 64'd0, 64'hFFFF_FFFF_FFFF_FFF7};
    int             el [4] = '{1, 9, 1, 1};
    int lat; bit to; int want;
    for (int i = 0; i < 4; i++) begin
      want = EARLY ? el[i] : ITERS;
      start_op(xs[i], ys[i]);
      wait_valid(lat, to);
      checks++; if (to || lat != want) begin errors++; $display("FAIL early_%0d_latency: got %0d (timeout=%0b) expected %0d", i, lat, to, want); end
      checks++; if (product !== ps[i]) begin errors++; $display("FAIL early_%0d_product: got %h expected %h", i, product, ps[i]); end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [W-1:0]   x, y;
    logic [2*W-1:0] want;
    longint         sx, sy;
    int lat; bit to;
    for (int i = 0; i < 300; i++) begin
      x = $urandom();
      y = $urandom();
      if (i % 4 == 1) y = W'($urandom_range(0, 511));
      if (i % 4 == 2) y = ~W'($urandom_range(0, 511));
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      want = sx * sy;
      start_op(x, y);
      wait_valid(lat, to);
      checks++; if (to || product !== want) begin errors++; $display("FAIL rand_%0d_product: x=%h y=%h got %h (timeout=%0b) expected %h", i, x, y, product, to, want); end
      checks++; if (lat != exp_lat(y)) begin errors++; $display("FAIL rand_%0d_latency: y=%h got %0d expected %0d", i, y, lat, exp_lat(y)); end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_backpressure();
    test_reset_mid_run();
    test_early_term();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
